// File: rtl/deb_main_pkg.sv
// Shared constants and helpers for the pushbutton/indicator debouncer.
//   B           MSB index of the CPU data bus (bus is B+1 bits)
//   DEB_CYCLES  stable cycles needed before a debounced level may change
//   HB_CYCLES   half-period of the heartbeat LED, in clocks
//   ADDR_BTN / ADDR_IND  register select values on the read port
package deb_main_pkg;

  localparam int   B          = 3;
  localparam int   DEB_CYCLES = 500000;
  localparam int   HB_CYCLES  = 25000000;

  localparam logic ADDR_BTN   = 1'b0;
  localparam logic ADDR_IND   = 1'b1;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_ACTIVE = 1'b1
  } rd_state_t;

  // 1-based index of the lowest set bit, 0 when no bit is set.
  function automatic logic [2:0] lowest_index(input logic [5:0] i_vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (i_vec[i]) idx = 3'(i + 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/deb_main_debounce_cell.sv
// Debounce cell for a single active-low board input.
//   clk      system clock
//   reset    asynchronous, active-high
//   i_raw    asynchronous raw input
//   o_level  debounced level (1 = released/inactive after reset)
// The input is brought in through two flops; the debounced level only
// follows it after DEB_CYCLES consecutive cycles of disagreement.
module deb_main_debounce_cell
  import deb_main_pkg::*;
#(
  parameter int DEB_CYCLES = deb_main_pkg::DEB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level
);

  localparam int              CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0]   TC = CW'(DEB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == TC) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/deb_main.sv
// Pushbutton / indicator debouncer with a CPU read port.
//   clk, reset        50 MHz clock, asynchronous active-high reset
//   sram_data         B+1-bit read data, high-Z unless ncs=0 and noe=0
//   addr, ncs, noe    async SRAM-style read strobe and register select
//   led_sie           heartbeat, toggles every HB_CYCLES clocks
//   irq               level interrupt: a press or indicator change is unread
//   PB_1..PB_5        active-low pushbuttons
//   IND1..IND6        active-low indicator inputs
// Address 0 returns the last pressed button (1..5), address 1 the
// lowest-numbered active indicator (1..6). The end of a read strobe clears
// the pending flag of the address latched when the strobe began.
//
// Read-strobe tracker:
//   state     | meaning
//   RD_IDLE   | no synchronised strobe; waiting for ncs=0 & noe=0
//   RD_ACTIVE | strobe seen, address latched; its end clears the pending flag
module deb_main
  import deb_main_pkg::*;
#(
  parameter int B          = deb_main_pkg::B,
  parameter int DEB_CYCLES = deb_main_pkg::DEB_CYCLES,
  parameter int HB_CYCLES  = deb_main_pkg::HB_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  output wire  [B:0] sram_data,
  input  logic       addr,
  input  logic       ncs,
  input  logic       noe,
  output logic       led_sie,
  output logic       irq,
  input  logic       PB_1,
  input  logic       PB_2,
  input  logic       PB_3,
  input  logic       PB_4,
  input  logic       PB_5,
  input  logic       IND1,
  input  logic       IND2,
  input  logic       IND3,
  input  logic       IND4,
  input  logic       IND5,
  input  logic       IND6
);

  localparam int            HW = (HB_CYCLES > 1) ? $clog2(HB_CYCLES) : 1;
  localparam logic [HW-1:0] HB_TC = HW'(HB_CYCLES - 1);

  logic [4:0] w_pb_raw;
  logic [4:0] w_pb_db;
  logic [5:0] w_ind_raw;
  logic [5:0] w_ind_db;

  assign w_pb_raw  = {PB_5, PB_4, PB_3, PB_2, PB_1};
  assign w_ind_raw = {IND6, IND5, IND4, IND3, IND2, IND1};

  for (genvar g = 0; g < 5; g++) begin : g_pb
    deb_main_debounce_cell #(.DEB_CYCLES(DEB_CYCLES)) u_cell (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (w_pb_raw[g]),
      .o_level (w_pb_db[g])
    );
  end

  for (genvar g = 0; g < 6; g++) begin : g_ind
    deb_main_debounce_cell #(.DEB_CYCLES(DEB_CYCLES)) u_cell (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (w_ind_raw[g]),
      .o_level (w_ind_db[g])
    );
  end

  logic          r_ncs_s1, r_ncs_s2;
  logic          r_noe_s1, r_noe_s2;
  logic          r_addr_s1, r_addr_s2;
  logic          r_rd_addr;
  rd_state_t     r_rd_state;
  rd_state_t     w_rd_state_nxt;
  logic          w_rd_sync;
  logic          w_rd_start;
  logic          w_rd_end;

  logic [4:0]    r_pb_prev;
  logic [4:0]    w_pb_fall;
  logic          w_press_evt;
  logic [2:0]    w_press_idx;
  logic [2:0]    w_ind_idx;
  logic          w_ind_chg;

  logic [2:0]    r_press_code, w_press_code_nxt;
  logic          r_press_pend, w_press_pend_nxt;
  logic [2:0]    r_ind_code;
  logic          r_ind_pend,   w_ind_pend_nxt;
  logic          r_irq;
  logic          r_led;
  logic [HW-1:0] r_hb_cnt;

  logic [B:0]    w_rd_data;
  logic          w_bus_oe;

  assign w_rd_sync   = ~r_ncs_s2 & ~r_noe_s2;
  // Falling edge of a debounced button is a press (buttons are active low).
  assign w_pb_fall   = r_pb_prev & ~w_pb_db;
  assign w_press_evt = |w_pb_fall;
  assign w_press_idx = lowest_index({1'b0, w_pb_fall});
  assign w_ind_idx   = lowest_index(~w_ind_db);
  assign w_ind_chg   = (w_ind_idx != r_ind_code);

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_start     = 1'b0;
    w_rd_end       = 1'b0;
    case (r_rd_state)
      RD_IDLE: begin
        if (w_rd_sync) begin
          w_rd_start     = 1'b1;
          w_rd_state_nxt = RD_ACTIVE;
        end
      end
      RD_ACTIVE: begin
        if (!w_rd_sync) begin
          w_rd_end       = 1'b1;
          w_rd_state_nxt = RD_IDLE;
        end
      end
      default: w_rd_state_nxt = RD_IDLE;
    endcase
  end

  // Clears are applied first so that an event in the same cycle overrides them.
  always_comb begin
    w_press_code_nxt = r_press_code;
    w_press_pend_nxt = r_press_pend;
    w_ind_pend_nxt   = r_ind_pend;
    if (w_rd_end && (r_rd_addr == ADDR_BTN)) begin
      w_press_code_nxt = 3'd0;
      w_press_pend_nxt = 1'b0;
    end
    if (w_rd_end && (r_rd_addr == ADDR_IND)) begin
      w_ind_pend_nxt = 1'b0;
    end
    if (w_press_evt) begin
      w_press_code_nxt = w_press_idx;
      w_press_pend_nxt = 1'b1;
    end
    if (w_ind_chg) begin
      w_ind_pend_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ncs_s1     <= 1'b1;
      r_ncs_s2     <= 1'b1;
      r_noe_s1     <= 1'b1;
      r_noe_s2     <= 1'b1;
      r_addr_s1    <= 1'b0;
      r_addr_s2    <= 1'b0;
      r_rd_addr    <= 1'b0;
      r_rd_state   <= RD_IDLE;
      r_pb_prev    <= '1;
      r_press_code <= 3'd0;
      r_press_pend <= 1'b0;
      r_ind_code   <= 3'd0;
      r_ind_pend   <= 1'b0;
      r_irq        <= 1'b0;
      r_led        <= 1'b0;
      r_hb_cnt     <= '0;
    end else begin
      r_ncs_s1     <= ncs;
      r_ncs_s2     <= r_ncs_s1;
      r_noe_s1     <= noe;
      r_noe_s2     <= r_noe_s1;
      r_addr_s1    <= addr;
      r_addr_s2    <= r_addr_s1;
      r_rd_state   <= w_rd_state_nxt;
      if (w_rd_start) r_rd_addr <= r_addr_s2;
      r_pb_prev    <= w_pb_db;
      r_press_code <= w_press_code_nxt;
      r_press_pend <= w_press_pend_nxt;
      r_ind_code   <= w_ind_idx;
      r_ind_pend   <= w_ind_pend_nxt;
      // Built from the next flag values so irq tracks the flags without lag.
      r_irq        <= w_press_pend_nxt | w_ind_pend_nxt;
      if (r_hb_cnt == HB_TC) begin
        r_hb_cnt <= '0;
        r_led    <= ~r_led;
      end else begin
        r_hb_cnt <= r_hb_cnt + 1'b1;
      end
    end
  end

  // The read path uses the raw strobe and address: the CPU expects data
  // within its access time, long before the synchronisers settle.
  always_comb begin
    w_rd_data      = '0;
    w_rd_data[2:0] = (addr == ADDR_BTN) ? r_press_code : r_ind_code;
  end

  assign w_bus_oe  = ~ncs & ~noe & ~reset;
  assign sram_data = w_bus_oe ? w_rd_data : {(B+1){1'bz}};

  assign irq     = r_irq;
  assign led_sie = r_led;

endmodule

// File: tb/tb_deb_main.sv
// Directed bench for deb_main with DEB_CYCLES=16 and HB_CYCLES=8.
// The bus carries pull-ups, so a floating sram_data reads as 4'b1111;
// driven data always has bit 3 low, so the two cases are distinct.
module tb_deb_main;

  logic       clk = 1'b0;
  logic       reset;
  logic       addr;
  logic       ncs;
  logic       noe;
  logic [4:0] pb;
  logic [5:0] ind;
  wire  [3:0] sram_data;
  wire        led_sie;
  wire        irq;

  int n_tests = 0;
  int n_fail  = 0;

  pullup (sram_data[0]);
  pullup (sram_data[1]);
  pullup (sram_data[2]);
  pullup (sram_data[3]);

  always #10 clk = ~clk;

  deb_main #(.B(3), .DEB_CYCLES(16), .HB_CYCLES(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .sram_data (sram_data),
    .addr      (addr),
    .ncs       (ncs),
    .noe       (noe),
    .led_sie   (led_sie),
    .irq       (irq),
    .PB_1      (pb[0]),
    .PB_2      (pb[1]),
    .PB_3      (pb[2]),
    .PB_4      (pb[3]),
    .PB_5      (pb[4]),
    .IND1      (ind[0]),
    .IND2      (ind[1]),
    .IND3      (ind[2]),
    .IND4      (ind[3]),
    .IND5      (ind[4]),
    .IND6      (ind[5])
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_irq(input string tag, input logic lvl, input int budget);
    int k = 0;
    while (irq !== lvl && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, {3'b000, irq}, {3'b000, lvl});
  endtask

  // Full read cycle from a negedge: data sampled 1 ns into the strobe,
  // strobe held 5 cycles, then 5 idle cycles for the synchronised clear.
  task automatic do_read(input logic a, output logic [3:0] data);
    addr = a;
    ncs  = 1'b0;
    noe  = 1'b0;
    #1 data = sram_data;
    tick(5);
    ncs = 1'b1;
    noe = 1'b1;
    tick(5);
  endtask

  logic [3:0] rd;

  initial begin
    reset = 1'b1;
    addr  = 1'b0;
    ncs   = 1'b1;
    noe   = 1'b1;
    pb    = 5'b11111;
    ind   = 6'b111111;

    #50;
    check("rst_irq",     {3'b000, irq},     4'b0000);
    check("rst_led",     {3'b000, led_sie}, 4'b0000);
    check("rst_bus_idle", sram_data,        4'b1111);
    ncs = 1'b0;
    noe = 1'b0;
    #5;
    check("rst_bus_sel",  sram_data,        4'b1111);
    ncs = 1'b1;
    noe = 1'b1;

    @(negedge clk);
    reset = 1'b0;

    tick(7);
    check("hb_7",  {3'b000, led_sie}, 4'b0000);
    tick(1);
    check("hb_8",  {3'b000, led_sie}, 4'b0001);
    tick(7);
    check("hb_15", {3'b000, led_sie}, 4'b0001);
    tick(1);
    check("hb_16", {3'b000, led_sie}, 4'b0000);

    do_read(1'b0, rd);
    check("rd0_after_rst", rd, 4'b0000);
    check("irq_after_rst", {3'b000, irq}, 4'b0000);

    // PB_1: one-cycle glitch, then a solid press.
    pb[0] = 1'b0; tick(1);
    pb[0] = 1'b1; tick(1);
    pb[0] = 1'b0;
    tick(15);
    check("pb1_early", {3'b000, irq}, 4'b0000);
    wait_irq("pb1_irq", 1'b1, 10);
    do_read(1'b0, rd);
    check("pb1_code", rd, 4'b0001);
    check("pb1_clr",  {3'b000, irq}, 4'b0000);
    pb[0] = 1'b1;
    tick(30);
    check("pb1_release", {3'b000, irq}, 4'b0000);

    // PB_3: 10-cycle glitch is rejected, 20-cycle press is accepted.
    pb[2] = 1'b0; tick(10);
    pb[2] = 1'b1; tick(30);
    check("pb3_glitch", {3'b000, irq}, 4'b0000);
    do_read(1'b0, rd);
    check("pb3_glitch_code", rd, 4'b0000);
    pb[2] = 1'b0;
    tick(20);
    wait_irq("pb3_irq", 1'b1, 10);
    do_read(1'b0, rd);
    check("pb3_code", rd, 4'b0011);
    check("pb3_clr",  {3'b000, irq}, 4'b0000);
    pb[2] = 1'b1;
    tick(30);

    // Indicators: IND4, then IND2 as well, then both released.
    ind[3] = 1'b0;
    wait_irq("ind4_irq", 1'b1, 30);
    do_read(1'b1, rd);
    check("ind4_code", rd, 4'b0100);
    check("ind4_clr",  {3'b000, irq}, 4'b0000);
    ind[1] = 1'b0;
    wait_irq("ind2_irq", 1'b1, 30);
    do_read(1'b1, rd);
    check("ind2_code", rd, 4'b0010);
    check("ind2_clr",  {3'b000, irq}, 4'b0000);
    ind[1] = 1'b1;
    ind[3] = 1'b1;
    wait_irq("ind_none_irq", 1'b1, 30);
    do_read(1'b1, rd);
    check("ind_none_code", rd, 4'b0000);
    check("ind_none_clr",  {3'b000, irq}, 4'b0000);

    // PB_2 and PB_5 together: lowest index wins.
    pb[1] = 1'b0;
    pb[4] = 1'b0;
    wait_irq("pb25_irq", 1'b1, 30);
    do_read(1'b0, rd);
    check("pb25_code", rd, 4'b0010);
    check("pb25_clr",  {3'b000, irq}, 4'b0000);
    pb[1] = 1'b1;
    pb[4] = 1'b1;
    tick(30);
    check("pb25_release", {3'b000, irq}, 4'b0000);

    // PB_4 left unread, then a PB_1 press lands in the read-clear cycle.
    pb[3] = 1'b0;
    wait_irq("pb4_irq", 1'b1, 30);
    pb[3] = 1'b1;
    tick(30);
    addr  = 1'b0;
    ncs   = 1'b0;
    noe   = 1'b0;
    pb[0] = 1'b0;
    #1;
    check("pb4_pending", sram_data, 4'b0100);
    tick(16);
    ncs = 1'b1;
    noe = 1'b1;
    tick(3);
    check("collide_irq", {3'b000, irq}, 4'b0001);
    tick(5);
    check("collide_irq_hold", {3'b000, irq}, 4'b0001);
    do_read(1'b0, rd);
    check("collide_code", rd, 4'b0001);
    check("collide_clr",  {3'b000, irq}, 4'b0000);

    // Reset asserted in the middle of a read.
    pb[4] = 1'b0;
    wait_irq("pb5_irq", 1'b1, 40);
    addr = 1'b0;
    ncs  = 1'b0;
    noe  = 1'b0;
    #1;
    check("pb5_code", sram_data, 4'b0101);
    #5 reset = 1'b1;
    #1;
    check("midrd_bus", sram_data, 4'b1111);
    check("midrd_irq", {3'b000, irq}, 4'b0000);
    tick(2);
    reset = 1'b0;
    ncs   = 1'b1;
    noe   = 1'b1;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
